// File: rtl/ibex_noc_pkg.sv
// Shared types for the NoC transmit path: message record, scheduler state and
// the number of optional payload words that follow the first data word.
package ibex_noc_pkg;

    localparam int NocMaxExtraWords = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        SEND = 2'd2
    } noc_tx_state_e;

    typedef struct packed {
        logic [4:0]  addr;
        logic [4:0]  core;
        logic [1:0]  len;
        logic [31:0] data;
        logic [31:0] msg1;
        logic [31:0] msg2;
        logic [31:0] msg3;
    } noc_msg_t;

endpackage

// File: rtl/ibex_rr_arbiter.sv
// Combinational round-robin pick: the first asserted request found scanning
// upward from ptr, wrapping at N-1 back to 0.
module ibex_rr_arbiter #(
    parameter int N    = 4,
    parameter int IdxW = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [IdxW-1:0] ptr,
    output logic [IdxW-1:0] gnt_idx,
    output logic            gnt_valid
);

    logic [IdxW:0]   sum;
    logic [IdxW-1:0] idx;

    always_comb begin
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        sum       = '0;
        idx       = '0;
        for (int k = 0; k < N; k++) begin
            sum = {1'b0, ptr} + (IdxW + 1)'(k);
            if (sum >= (IdxW + 1)'(N)) begin
                sum = sum - (IdxW + 1)'(N);
            end
            idx = sum[IdxW-1:0];
            if (!gnt_valid && req[idx]) begin
                gnt_valid = 1'b1;
                gnt_idx   = idx;
            end
        end
    end

endmodule

// File: rtl/ibex_noc_tx_arbiter.sv
// Shares one NoC injection port among NumReq message sources: captures the
// round-robin winner's message, runs the noc_req/noc_gnt handshake, then acks.
module ibex_noc_tx_arbiter
    import ibex_noc_pkg::*;
#(
    parameter int NumReq = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NumReq-1:0]    req_valid_i,
    input  logic [2*NumReq-1:0]  req_len_i,
    input  logic [32*NumReq-1:0] req_data_i,
    input  logic [32*NumReq-1:0] req_msg1_i,
    input  logic [32*NumReq-1:0] req_msg2_i,
    input  logic [32*NumReq-1:0] req_msg3_i,
    input  logic [5*NumReq-1:0]  req_addr_i,
    input  logic [5*NumReq-1:0]  req_core_i,
    output logic [NumReq-1:0]    req_ack_o,
    output logic                 noc_req_o,
    input  logic                 noc_gnt_i,
    output logic                 output_valid_o,
    output logic [1:0]           len_o,
    output logic [31:0]          output_data_o,
    output logic [31:0]          msg1_data_o,
    output logic [31:0]          msg2_data_o,
    output logic [31:0]          msg3_data_o,
    output logic [4:0]           output_addr_o,
    output logic [4:0]           output_core_o,
    output logic                 busy_o
);

    localparam int IdxW = $clog2(NumReq);

    noc_tx_state_e   state;
    logic [IdxW-1:0] ptr;
    logic [IdxW-1:0] winner;
    logic [IdxW-1:0] gnt_idx;
    logic            gnt_valid;
    noc_msg_t        msg;
    noc_msg_t        pick_msg;

    ibex_rr_arbiter #(
        .N    (NumReq),
        .IdxW (IdxW)
    ) u_rr_arbiter (
        .req       (req_valid_i),
        .ptr       (ptr),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    // Extra words beyond the requester's declared length are stored as zero.
    always_comb begin
        pick_msg      = '0;
        pick_msg.addr = req_addr_i[5*gnt_idx +: 5];
        pick_msg.core = req_core_i[5*gnt_idx +: 5];
        pick_msg.len  = req_len_i[2*gnt_idx +: 2];
        pick_msg.data = req_data_i[32*gnt_idx +: 32];
        if (pick_msg.len >= 2'd1) begin
            pick_msg.msg1 = req_msg1_i[32*gnt_idx +: 32];
        end
        if (pick_msg.len >= 2'd2) begin
            pick_msg.msg2 = req_msg2_i[32*gnt_idx +: 32];
        end
        if (pick_msg.len == 2'(NocMaxExtraWords)) begin
            pick_msg.msg3 = req_msg3_i[32*gnt_idx +: 32];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state  <= IDLE;
            ptr    <= '0;
            winner <= '0;
            msg    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_valid) begin
                        msg    <= pick_msg;
                        winner <= gnt_idx;
                        state  <= REQ;
                    end
                end
                REQ: begin
                    if (noc_gnt_i) begin
                        state <= SEND;
                    end
                end
                SEND: begin
                    ptr   <= (winner == IdxW'(NumReq - 1)) ? '0 : winner + 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Handshake outputs are pure decodes of the state register.
    assign noc_req_o      = (state == REQ);
    assign output_valid_o = (state == SEND);
    assign busy_o         = (state != IDLE);
    assign req_ack_o      = output_valid_o ? (NumReq'(1) << winner) : '0;

    assign len_o         = msg.len;
    assign output_data_o = msg.data;
    assign msg1_data_o   = msg.msg1;
    assign msg2_data_o   = msg.msg2;
    assign msg3_data_o   = msg.msg3;
    assign output_addr_o = msg.addr;
    assign output_core_o = msg.core;

endmodule

// File: tb/tb_ibex_noc_tx_arbiter.sv
// Bench for ibex_noc_tx_arbiter: directed and randomized transfers checked
// against a transaction-level model of requesters, pointer and payload masking.
module tb_ibex_noc_tx_arbiter;

    localparam int N = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req_valid;
    logic [2*N-1:0]  req_len;
    logic [32*N-1:0] req_data, req_msg1, req_msg2, req_msg3;
    logic [5*N-1:0]  req_addr, req_core;
    logic [N-1:0]  req_ack;
    logic          noc_req, noc_gnt, output_valid, busy;
    logic [1:0]    len;
    logic [31:0]   output_data, msg1_data, msg2_data, msg3_data;
    logic [4:0]    output_addr, output_core;

    ibex_noc_tx_arbiter #(.NumReq(N)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .req_valid_i    (req_valid),
        .req_len_i      (req_len),
        .req_data_i     (req_data),
        .req_msg1_i     (req_msg1),
        .req_msg2_i     (req_msg2),
        .req_msg3_i     (req_msg3),
        .req_addr_i     (req_addr),
        .req_core_i     (req_core),
        .req_ack_o      (req_ack),
        .noc_req_o      (noc_req),
        .noc_gnt_i      (noc_gnt),
        .output_valid_o (output_valid),
        .len_o          (len),
        .output_data_o  (output_data),
        .msg1_data_o    (msg1_data),
        .msg2_data_o    (msg2_data),
        .msg3_data_o    (msg3_data),
        .output_addr_o  (output_addr),
        .output_core_o  (output_core),
        .busy_o         (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Requester-side model: what each source currently presents.
    bit          mv[N];
    logic [1:0]  mlen[N];
    logic [31:0] md[N], m1[N], m2[N], m3[N];
    logic [4:0]  ma[N], mc[N];
    int          mptr;

    typedef struct {
        logic [1:0]  len;
        logic [31:0] d, w1, w2, w3;
        logic [4:0]  a, c;
    } pay_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_valid[i]         = mv[i];
            req_len[2*i +: 2]    = mlen[i];
            req_data[32*i +: 32] = md[i];
            req_msg1[32*i +: 32] = m1[i];
            req_msg2[32*i +: 32] = m2[i];
            req_msg3[32*i +: 32] = m3[i];
            req_addr[5*i +: 5]   = ma[i];
            req_core[5*i +: 5]   = mc[i];
        end
    endtask

    task automatic rand_msg(input int i);
        mlen[i] = 2'($urandom_range(0, 3));
        md[i]   = $urandom;
        m1[i]   = $urandom;
        m2[i]   = $urandom;
        m3[i]   = $urandom;
        ma[i]   = 5'($urandom);
        mc[i]   = 5'($urandom);
    endtask

    function automatic int pick();
        for (int k = 0; k < N; k++) begin
            if (mv[(mptr + k) % N]) return (mptr + k) % N;
        end
        return -1;
    endfunction

    function automatic bit any_valid();
        for (int i = 0; i < N; i++) if (mv[i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic pay_t expect_pay(input int w);
        pay_t p;
        p.len = mlen[w];
        p.d   = md[w];
        p.w1  = (mlen[w] >= 1) ? m1[w] : 32'h0;
        p.w2  = (mlen[w] >= 2) ? m2[w] : 32'h0;
        p.w3  = (mlen[w] == 3) ? m3[w] : 32'h0;
        p.a   = ma[w];
        p.c   = mc[w];
        return p;
    endfunction

    task automatic check_pay(input string tag, input pay_t p);
        chk({tag, ".len"},  32'(len),         32'(p.len));
        chk({tag, ".data"}, output_data,      p.d);
        chk({tag, ".msg1"}, msg1_data,        p.w1);
        chk({tag, ".msg2"}, msg2_data,        p.w2);
        chk({tag, ".msg3"}, msg3_data,        p.w3);
        chk({tag, ".addr"}, 32'(output_addr), 32'(p.a));
        chk({tag, ".core"}, 32'(output_core), 32'(p.c));
    endtask

    task automatic check_ctrl(input string tag, input bit r, input bit v, input bit b, input logic [N-1:0] a);
        chk({tag, ".noc_req"}, 32'(noc_req),      32'(r));
        chk({tag, ".ovalid"},  32'(output_valid), 32'(v));
        chk({tag, ".busy"},    32'(busy),         32'(b));
        chk({tag, ".ack"},     32'(req_ack),      32'(a));
    endtask

    task automatic check_zero(input string tag);
        pay_t z;
        z = '{len: 2'd0, d: 32'h0, w1: 32'h0, w2: 32'h0, w3: 32'h0, a: 5'd0, c: 5'd0};
        check_ctrl(tag, 1'b0, 1'b0, 1'b0, '0);
        check_pay(tag, z);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            noc_gnt = 1'($urandom_range(0, 1));
            tick();
            check_ctrl("idle", 1'b0, 1'b0, 1'b0, '0);
        end
        noc_gnt = 1'b0;
    endtask

    // One complete transfer from the current IDLE cycle: capture, REQ held for
    // 'delay' ungranted cycles, SEND, return to IDLE.
    task automatic xfer(input int ew, input int delay, input int late, input int late_at,
                        input bit keep, output int w);
        pay_t p;
        w = (ew >= 0) ? ew : pick();
        if (w < 0) begin
            $display("FAIL xfer_setup observed=no requester expected=one valid requester");
            $fatal(1, "no valid requester for transfer");
        end
        p = expect_pay(w);
        tick();
        check_ctrl("req", 1'b1, 1'b0, 1'b1, '0);
        check_pay("req", p);
        for (int i = 0; i < delay; i++) begin
            noc_gnt = 1'b0;
            if (i == late_at && late >= 0 && !mv[late]) begin
                mv[late] = 1'b1;
                rand_msg(late);
                drive();
            end
            tick();
            check_ctrl("wait", 1'b1, 1'b0, 1'b1, '0);
            check_pay("wait", p);
        end
        noc_gnt = 1'b1;
        tick();
        check_ctrl("send", 1'b0, 1'b1, 1'b1, N'(1) << w);
        check_pay("send", p);
        noc_gnt = 1'($urandom_range(0, 1));
        mptr = (w + 1) % N;
        if (keep) rand_msg(w);
        else mv[w] = 1'b0;
        drive();
        tick();
        check_ctrl("done", 1'b0, 1'b0, 1'b0, '0);
        check_pay("done", p);
        noc_gnt = 1'b0;
    endtask

    initial begin
        int w;
        int order[10] = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1};
        rst = 1'b1;
        noc_gnt = 1'b0;
        for (int i = 0; i < N; i++) begin
            mv[i] = 1'b0; mlen[i] = '0; md[i] = '0; m1[i] = '0; m2[i] = '0; m3[i] = '0;
            ma[i] = '0; mc[i] = '0;
        end
        drive();
        #12;
        check_zero("reset");
        rst  = 1'b0;
        mptr = 0;

        // Single requester, grant immediate, msg2/msg3 must be masked.
        mv[2] = 1'b1; mlen[2] = 2'd1; md[2] = 32'hDEADBEEF; m1[2] = 32'h1234;
        m2[2] = 32'hBADC0DE5; m3[2] = 32'h5A5A5A5A; ma[2] = 5'd5; mc[2] = 5'd3;
        drive();
        xfer(2, 0, -1, 0, 1'b0, w);

        rst = 1'b1;
        #2;
        check_zero("reset_pulse");
        rst  = 1'b0;
        mptr = 0;

        // All four continuously valid, then drained.
        for (int i = 0; i < N; i++) begin
            mv[i] = 1'b1;
            rand_msg(i);
        end
        drive();
        for (int k = 0; k < 10; k++) xfer(order[k], 0, -1, 0, k < 6, w);

        idle_cycles(4);

        // Backpressure for 10 cycles; requester 1 rises during the wait.
        mv[3] = 1'b1; rand_msg(3); drive();
        xfer(3, 10, 1, 4, 1'b0, w);
        xfer(1, $urandom_range(0, 2), -1, 0, 1'b0, w);

        // Wrap-around after a grant to requester 3.
        mv[0] = 1'b1; rand_msg(0); mv[3] = 1'b1; rand_msg(3); drive();
        xfer(3, 0, -1, 0, 1'b1, w);
        xfer(0, 1, -1, 0, 1'b0, w);
        xfer(3, 0, -1, 0, 1'b0, w);
        idle_cycles(2);

        // Randomized traffic against the model.
        for (int it = 0; it < 24; it++) begin
            for (int i = 0; i < N; i++) begin
                if (!mv[i] && $urandom_range(0, 1) == 1) begin
                    mv[i] = 1'b1;
                    rand_msg(i);
                end
            end
            if (!any_valid()) begin
                mv[it % N] = 1'b1;
                rand_msg(it % N);
            end
            drive();
            xfer(-1, $urandom_range(0, 3), $urandom_range(0, N - 1), $urandom_range(0, 2),
                 1'($urandom_range(0, 1)), w);
        end
        for (int k = 0; k < N; k++) begin
            if (any_valid()) xfer(-1, 0, -1, 0, 1'b0, w);
        end
        idle_cycles(2);

        // Asynchronous reset while waiting for grant.
        mv[2] = 1'b1; rand_msg(2); drive();
        noc_gnt = 1'b0;
        tick();
        check_ctrl("pre_rst", 1'b1, 1'b0, 1'b1, '0);
        tick();
        #3 rst = 1'b1;
        #1 check_zero("async_rst");
        mv[2] = 1'b0;
        mv[3] = 1'b1; rand_msg(3); drive();
        mptr = 0;
        tick();
        check_zero("rst_held");
        #2 rst = 1'b0;
        xfer(3, 0, -1, 0, 1'b0, w);
        idle_cycles(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
